// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types
// Description : Shared types and constants for the rv32i pipeline control
//               logic: the hazard controller state encoding, the canonical
//               NOP instruction and a register-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

   // Hazard controller sequencing states.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_LU_STALL = 2'd2
   } hz_state_e;

   // addi x0, x0, 0 : the canonical rv32i NOP inserted by bubbles and flushes.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Width of the load-use bubble counter (covers up to 3 bubbles).
   localparam int LU_CNT_W = 2;

   // True when an operand is actually read and names the given register.
   function automatic logic src_hits(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic [4:0] dest);
      return use_src && (src == dest);
   endfunction

endpackage : rv32i_types
`default_nettype wire

// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Interface   : hazard_controller_if
// Description : Bundles the pipeline-side signals seen by the hazard
//               controller: cache handshakes, EX/MEM operand information,
//               branch resolution, and the per-stage hold/bubble/flush
//               controls returned to the pipeline.
//   master : pipeline datapath (drives status, receives controls)
//   slave  : hazard controller (receives status, drives controls)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_controller_if;

   // Cache handshakes
   logic       imem_read;
   logic       imem_resp;
   logic       dmem_read;
   logic       dmem_write;
   logic       dmem_resp;

   // Operand / destination information for load-use detection
   logic [4:0] id_ex_src1;
   logic [4:0] id_ex_src2;
   logic       id_ex_use1;
   logic       id_ex_use2;
   logic [4:0] ex_mem_dest;
   logic       ex_mem_is_load;

   // Branch resolution from EX
   logic       br_taken;

   // Pipeline controls
   logic       hold_if;
   logic       hold_id;
   logic       hold_ex;
   logic       hold_mem;
   logic       bubble_mem;
   logic       flush_if_id;
   logic       flush_id_ex;
   logic       pc_redirect;

   modport master (
      output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
      output id_ex_src1, id_ex_src2, id_ex_use1, id_ex_use2,
      output ex_mem_dest, ex_mem_is_load, br_taken,
      input  hold_if, hold_id, hold_ex, hold_mem, bubble_mem,
      input  flush_if_id, flush_id_ex, pc_redirect
   );

   modport slave (
      input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
      input  id_ex_src1, id_ex_src2, id_ex_use1, id_ex_use2,
      input  ex_mem_dest, ex_mem_is_load, br_taken,
      output hold_if, hold_id, hold_ex, hold_mem, bubble_mem,
      output flush_if_id, flush_id_ex, pc_redirect
   );

endinterface : hazard_controller_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears the count
//   en    : count this cycle
//   count : current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline sequencing controller for the 5-stage rv32i core.
//               Converts cache waits, load-use hazards and taken branches
//               into per-stage hold, bubble and flush controls, and keeps
//               saturating stall / flush performance counters.
//   clk          : core clock
//   rst          : asynchronous active-low reset
//   bus          : hazard_controller_if.slave (handshakes in, controls out)
//   stall_cycles : cycles with any stage held
//   flush_count  : redirects performed
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
   import rv32i_types::*;
#(
   parameter int CNT_W      = 32,
   parameter int LU_BUBBLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_controller_if.slave   bus,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_count
);

   // Remaining bubbles after the one issued on the detection cycle.
   localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LU_BUBBLES - 1);

   hz_state_e           state;
   hz_state_e           state_nxt;
   logic [LU_CNT_W-1:0] lu_cnt;
   logic [LU_CNT_W-1:0] lu_cnt_nxt;
   logic                redirect_pending;
   logic                pending_nxt;
   // Low for the first cycle after reset so all controls stay quiet then.
   logic                out_en;

   logic mem_busy;
   logic lu_hazard;

   logic hold_if_c;
   logic hold_id_c;
   logic hold_ex_c;
   logic hold_mem_c;
   logic bubble_c;
   logic redirect_c;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   assign mem_busy = ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp)
                   | (bus.imem_read & ~bus.imem_resp);

   // Loads into x0 never produce data, so they never create a dependency.
   assign lu_hazard = bus.ex_mem_is_load
                    & (bus.ex_mem_dest != 5'd0)
                    & ( src_hits(bus.id_ex_use1, bus.id_ex_src1, bus.ex_mem_dest)
                      | src_hits(bus.id_ex_use2, bus.id_ex_src2, bus.ex_mem_dest));

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_RUN;
         lu_cnt           <= '0;
         redirect_pending <= 1'b0;
         out_en           <= 1'b0;
      end else begin
         state            <= state_nxt;
         lu_cnt           <= lu_cnt_nxt;
         redirect_pending <= pending_nxt;
         out_en           <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and control outputs. Priority: memory wait, then load-use,
   // then redirect. A branch that cannot be served now is parked in
   // redirect_pending and retried on the first free cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      lu_cnt_nxt  = lu_cnt;
      pending_nxt = redirect_pending;
      hold_if_c   = 1'b0;
      hold_id_c   = 1'b0;
      hold_ex_c   = 1'b0;
      hold_mem_c  = 1'b0;
      bubble_c    = 1'b0;
      redirect_c  = 1'b0;

      if (!out_en) begin
         state_nxt = ST_RUN;
      end else if (mem_busy) begin
         // Freeze the whole pipe; the response cycle itself is not held.
         hold_if_c  = 1'b1;
         hold_id_c  = 1'b1;
         hold_ex_c  = 1'b1;
         hold_mem_c = 1'b1;
         state_nxt  = ST_MEM_WAIT;
         if (bus.br_taken) begin
            pending_nxt = 1'b1;
         end
      end else if (state == ST_LU_STALL) begin
         // Extra bubbles: the load is already gone, so no re-detection.
         hold_if_c  = 1'b1;
         hold_id_c  = 1'b1;
         bubble_c   = 1'b1;
         lu_cnt_nxt = lu_cnt - 1'b1;
         if (lu_cnt <= 2'd1) begin
            lu_cnt_nxt = '0;
            state_nxt  = ST_RUN;
         end
         if (bus.br_taken) begin
            pending_nxt = 1'b1;
         end
      end else if (lu_hazard) begin
         // Hold IF/ID, bubble EX/MEM, let the load drain into MEM/WB.
         hold_if_c = 1'b1;
         hold_id_c = 1'b1;
         bubble_c  = 1'b1;
         if (LU_BUBBLES > 1) begin
            lu_cnt_nxt = LU_INIT;
            state_nxt  = ST_LU_STALL;
         end else begin
            state_nxt  = ST_RUN;
         end
         if (bus.br_taken) begin
            pending_nxt = 1'b1;
         end
      end else begin
         state_nxt = ST_RUN;
         if (bus.br_taken || redirect_pending) begin
            redirect_c  = 1'b1;
            pending_nxt = 1'b0;
         end
      end
   end

   assign bus.hold_if     = hold_if_c;
   assign bus.hold_id     = hold_id_c;
   assign bus.hold_ex     = hold_ex_c;
   assign bus.hold_mem    = hold_mem_c;
   assign bus.bubble_mem  = bubble_c;
   assign bus.pc_redirect = redirect_c;
   assign bus.flush_if_id = redirect_c;
   assign bus.flush_id_ex = redirect_c;

   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (hold_if_c | hold_id_c | hold_ex_c | hold_mem_c),
      .count (stall_cycles)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (redirect_c),
      .count (flush_count)
   );

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Scoreboard bench for hazard_controller. Two instances share
//               the same stimulus: dut1 (LU_BUBBLES=1, 32-bit counters) and
//               dut3 (LU_BUBBLES=3, 2-bit counters to reach saturation).
//               Each directed vector pushes its hand-computed expectation;
//               a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

   // {hold_if, hold_id, hold_ex, hold_mem, bubble_mem, flush_if_id,
   //  flush_id_ex, pc_redirect}
   localparam logic [7:0] O_NONE = 8'b0000_0000;
   localparam logic [7:0] O_HOLD = 8'b1111_0000;
   localparam logic [7:0] O_LU   = 8'b1100_1000;
   localparam logic [7:0] O_RED  = 8'b0000_0111;

   typedef struct {
      string      name;
      logic [7:0] o;
      int         s;
      int         f;
      bit         c3;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] stall1;
   logic [31:0] flush1;
   logic [1:0]  stall3;
   logic [1:0]  flush3;

   exp_t        q[$];
   exp_t        e;
   logic [7:0]  got_o;
   logic [31:0] got_s;
   logic [31:0] got_f;
   int          n_vec;
   int          n_err;

   hazard_controller_if bus1 ();
   hazard_controller_if bus3 ();

   hazard_controller #(
      .CNT_W      (32),
      .LU_BUBBLES (1)
   ) dut1 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus1),
      .stall_cycles (stall1),
      .flush_count  (flush1)
   );

   hazard_controller #(
      .CNT_W      (2),
      .LU_BUBBLES (3)
   ) dut3 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus3),
      .stall_cycles (stall3),
      .flush_count  (flush3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Monitor: one expectation per cycle, checked mid-cycle.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.c3) begin
            got_o = {bus3.hold_if, bus3.hold_id, bus3.hold_ex, bus3.hold_mem,
                     bus3.bubble_mem, bus3.flush_if_id, bus3.flush_id_ex,
                     bus3.pc_redirect};
            got_s = {30'd0, stall3};
            got_f = {30'd0, flush3};
         end else begin
            got_o = {bus1.hold_if, bus1.hold_id, bus1.hold_ex, bus1.hold_mem,
                     bus1.bubble_mem, bus1.flush_if_id, bus1.flush_id_ex,
                     bus1.pc_redirect};
            got_s = stall1;
            got_f = flush1;
         end
         n_vec++;
         if ((got_o !== e.o) || (got_s !== 32'(e.s)) || (got_f !== 32'(e.f))) begin
            n_err++;
            $display("FAIL %s (dut%0d): got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                     e.name, e.c3 ? 3 : 1, got_o, got_s, got_f, e.o, e.s, e.f);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic cyc(input string name, input logic rst_v,
                      input logic ir, input logic is_, input logic dr,
                      input logic dw, input logic ds,
                      input logic [4:0] s1, input logic u1,
                      input logic [4:0] s2, input logic u2,
                      input logic [4:0] md, input logic ml, input logic bt,
                      input logic [7:0] eo, input int es, input int ef,
                      input bit c3);
      exp_t x;
      @(posedge clk);
      #1;
      rst                 = rst_v;
      bus1.imem_read      = ir;   bus3.imem_read      = ir;
      bus1.imem_resp      = is_;  bus3.imem_resp      = is_;
      bus1.dmem_read      = dr;   bus3.dmem_read      = dr;
      bus1.dmem_write     = dw;   bus3.dmem_write     = dw;
      bus1.dmem_resp      = ds;   bus3.dmem_resp      = ds;
      bus1.id_ex_src1     = s1;   bus3.id_ex_src1     = s1;
      bus1.id_ex_use1     = u1;   bus3.id_ex_use1     = u1;
      bus1.id_ex_src2     = s2;   bus3.id_ex_src2     = s2;
      bus1.id_ex_use2     = u2;   bus3.id_ex_use2     = u2;
      bus1.ex_mem_dest    = md;   bus3.ex_mem_dest    = md;
      bus1.ex_mem_is_load = ml;   bus3.ex_mem_is_load = ml;
      bus1.br_taken       = bt;   bus3.br_taken       = bt;
      x.name = name;
      x.o    = eo;
      x.s    = es;
      x.f    = ef;
      x.c3   = c3;
      q.push_back(x);
   endtask

   task automatic idle(input string name, input logic [7:0] eo,
                       input int es, input int ef, input bit c3);
      cyc(name, 1'b1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, eo, es, ef, c3);
   endtask

   task automatic br(input string name, input logic [7:0] eo,
                     input int es, input int ef, input bit c3);
      cyc(name, 1'b1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, eo, es, ef, c3);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      bus1.imem_read = 0; bus1.imem_resp = 0; bus1.dmem_read = 0;
      bus1.dmem_write = 0; bus1.dmem_resp = 0; bus1.id_ex_src1 = 0;
      bus1.id_ex_src2 = 0; bus1.id_ex_use1 = 0; bus1.id_ex_use2 = 0;
      bus1.ex_mem_dest = 0; bus1.ex_mem_is_load = 0; bus1.br_taken = 0;
      bus3.imem_read = 0; bus3.imem_resp = 0; bus3.dmem_read = 0;
      bus3.dmem_write = 0; bus3.dmem_resp = 0; bus3.id_ex_src1 = 0;
      bus3.id_ex_src2 = 0; bus3.id_ex_use1 = 0; bus3.id_ex_use2 = 0;
      bus3.ex_mem_dest = 0; bus3.ex_mem_is_load = 0; bus3.br_taken = 0;

      // Reset and the quiet first cycle after release
      cyc("rst_hold", 0, 0,0,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_NONE, 0, 0, 0);
      cyc("rst_hold", 0, 0,0,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_NONE, 0, 0, 0);
      idle("rst_first", O_NONE, 0, 0, 0);
      idle("idle", O_NONE, 0, 0, 0);

      // lw x5 ; add x6,x5,x1 -> one bubble
      cyc("lu1_hazard", 1, 0,0,0,0,0, 5'd5,1, 5'd1,1, 5'd5,1,0, O_LU, 0, 0, 0);
      idle("lu1_after", O_NONE, 1, 0, 0);
      idle("lu1_idle", O_NONE, 1, 0, 0);
      idle("lu1_idle", O_NONE, 1, 0, 0);
      idle("lu1_idle", O_NONE, 1, 0, 0);

      // Load into x0, and a matching non-load: no stall
      cyc("x0_load", 1, 0,0,0,0,0, 5'd0,1, 5'd0,1, 5'd0,1,0, O_NONE, 1, 0, 0);
      cyc("rd_nonload", 1, 0,0,0,0,0, 5'd3,1, 5'd0,0, 5'd3,0,0, O_NONE, 1, 0, 0);

      // dmem load miss: 4 held cycles, response cycle advances
      for (int i = 0; i < 4; i++)
         cyc("dmem_wait", 1, 0,0,1,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_HOLD, 1 + i, 0, 0);
      cyc("dmem_resp", 1, 0,0,1,0,1, 5'd0,0, 5'd0,0, 5'd0,0,0, O_NONE, 5, 0, 0);
      idle("dmem_after", O_NONE, 5, 0, 0);
      cyc("dmemw_wait", 1, 0,0,0,1,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_HOLD, 5, 0, 0);
      cyc("dmemw_resp", 1, 0,0,0,1,1, 5'd0,0, 5'd0,0, 5'd0,0,0, O_NONE, 6, 0, 0);
      idle("dmemw_after", O_NONE, 6, 0, 0);

      // Branch during imem miss: deferred to the response cycle
      cyc("imem_br", 1, 1,0,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,1, O_HOLD, 6, 0, 0);
      cyc("imem_wait", 1, 1,0,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_HOLD, 7, 0, 0);
      cyc("imem_wait", 1, 1,0,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_HOLD, 8, 0, 0);
      cyc("imem_resp_redir", 1, 1,1,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_RED, 9, 0, 0);
      idle("imem_after", O_NONE, 9, 1, 0);
      idle("imem_no_repeat", O_NONE, 9, 1, 0);

      // Branch together with imem response: redirect, no hold
      cyc("br_with_iresp", 1, 1,1,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,1, O_RED, 9, 1, 0);
      idle("br_iresp_after", O_NONE, 9, 2, 0);

      // Plain branch
      br("br_plain", O_RED, 9, 2, 0);
      idle("br_plain_after", O_NONE, 9, 3, 0);

      // Branch asserted with load-use: bubble first, redirect next cycle
      cyc("br_with_lu", 1, 0,0,0,0,0, 5'd0,0, 5'd7,1, 5'd7,1,1, O_LU, 9, 3, 0);
      idle("br_deferred", O_RED, 10, 3, 0);
      idle("br_def_after", O_NONE, 10, 4, 0);

      // Reset in MEM_WAIT with a pending redirect
      cyc("mw_br", 1, 0,0,1,0,0, 5'd0,0, 5'd0,0, 5'd0,0,1, O_HOLD, 10, 4, 0);
      cyc("mw_wait", 1, 0,0,1,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_HOLD, 11, 4, 0);
      cyc("rst_mid", 0, 0,0,1,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_NONE, 0, 0, 0);
      cyc("rst_mid2", 0, 0,0,0,0,0, 5'd0,0, 5'd0,0, 5'd0,0,0, O_NONE, 0, 0, 0);
      idle("rst_release", O_NONE, 0, 0, 0);
      idle("no_redir_after_rst", O_NONE, 0, 0, 0);
      idle("no_redir_after_rst", O_NONE, 0, 0, 0);

      // dut3: three bubbles per hazard, 2-bit counters saturate at 3
      cyc("lu3_hazard", 1, 0,0,0,0,0, 5'd5,1, 5'd0,0, 5'd5,1,0, O_LU, 0, 0, 1);
      idle("lu3_bubble2", O_LU, 1, 0, 1);
      idle("lu3_bubble3", O_LU, 2, 0, 1);
      idle("lu3_done", O_NONE, 3, 0, 1);
      idle("lu3_run", O_NONE, 3, 0, 1);
      cyc("lu3_sat_hazard", 1, 0,0,0,0,0, 5'd0,0, 5'd9,1, 5'd9,1,0, O_LU, 3, 0, 1);
      idle("lu3_sat_b2", O_LU, 3, 0, 1);
      idle("lu3_sat_b3", O_LU, 3, 0, 1);
      idle("lu3_sat_done", O_NONE, 3, 0, 1);
      br("flush_sat", O_RED, 3, 0, 1);
      br("flush_sat", O_RED, 3, 1, 1);
      br("flush_sat", O_RED, 3, 2, 1);
      br("flush_sat", O_RED, 3, 3, 1);
      idle("flush_sat_hold", O_NONE, 3, 3, 1);
      br("flush_sat_more", O_RED, 3, 3, 1);
      idle("flush_sat_final", O_NONE, 3, 3, 1);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_hazard_controller
`default_nettype wire
